div_iter: RTL and testbench

- Sequential signed 32-bit integer divider for the multdiv unit.
- Companion of the multiply path: it inverts the multiply operation by repeated trial subtraction, one quotient bit per clock.
- Uses one restoring iteration per cycle, then a sign-fix cycle.
- Presents the same start/ready handshake to the processor as the multiplier.

---
 rtl/div_iter_pkg.sv | 43 ++++
 rtl/div_iter_if.sv | 24 ++
 rtl/div_iter_step.sv | 25 ++
 rtl/div_iter.sv | 114 +++++++++++
 tb/tb_div_iter.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: widths, FSM states and
// the carry-lookahead adder reused by the step logic and the sign fix.
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // 33-bit generate/propagate adder; one extra bit carries the sign of a
    // trial subtraction.
    function automatic logic [DIV_WIDTH:0] cla_add(input logic [DIV_WIDTH:0] a,
                                                   input logic [DIV_WIDTH:0] b,
                                                   input logic               cin);
        logic [DIV_WIDTH:0] p;
        logic [DIV_WIDTH:0] c;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
        end
        return p ^ c;
    endfunction

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        logic [DIV_WIDTH:0] s;
        s = cla_add({1'b1, ~x}, '0, 1'b1);
        return s[DIV_WIDTH-1:0];
    endfunction

    // 0x80000000 maps to itself, read as an unsigned magnitude.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Processor-side start/ready handshake of the divider, shared with the
// multiplier path.
interface div_iter_if;
    import div_iter_pkg::*;

    logic                 ctrl_DIV;
    logic [DIV_WIDTH-1:0] data_operandA;
    logic [DIV_WIDTH-1:0] data_operandB;
    logic [DIV_WIDTH-1:0] data_result;
    logic                 data_exception;
    logic                 data_resultRDY;
    logic                 busy;

    modport master (
        output ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/div_iter_step.sv
// One restoring division iteration: shift {R,Q} left, trial-subtract |B|,
// keep the difference and set the quotient bit when it is non-negative.
module div_step
    import div_iter_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] r,
    input  logic [DIV_WIDTH-1:0] q,
    input  logic [DIV_WIDTH-1:0] b_abs,
    output logic [DIV_WIDTH-1:0] r_nx,
    output logic [DIV_WIDTH-1:0] q_nx
);

    logic [DIV_WIDTH:0] r_sh;
    logic [DIV_WIDTH:0] trial;
    logic               neg;

    assign r_sh  = {r, q[DIV_WIDTH-1]};
    // R - |B| as R + ~|B| + 1 on the shared adder.
    assign trial = cla_add(r_sh, ~{1'b0, b_abs}, 1'b1);
    assign neg   = trial[DIV_WIDTH];

    assign r_nx = neg ? r_sh[DIV_WIDTH-1:0] : trial[DIV_WIDTH-1:0];
    assign q_nx = {q[DIV_WIDTH-2:0], ~neg};

endmodule

// File: rtl/div_iter.sv
// Sequential signed divider: 32 restoring steps on magnitudes, then one
// sign-fix cycle; divide-by-zero completes immediately with an exception.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic       clock,
    input logic       reset,
    div_iter_if.slave bus
);

    state_t             state;
    state_t             state_nx;
    logic               sa;
    logic               sb;
    logic               ovf;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   r;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   r_nx;
    logic [WIDTH-1:0]   q_nx;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   result_r;
    logic               exc_r;
    logic               start;
    logic               div_zero;
    logic               last_step;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    assign start     = bus.ctrl_DIV;
    assign div_zero  = (bus.data_operandB == '0);
    assign last_step = (count == CNT_W'(DIV_ITER - 1));

    div_step u_step (
        .r     (r),
        .q     (q),
        .b_abs (abs_b),
        .r_nx  (r_nx),
        .q_nx  (q_nx)
    );

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: next state defaults to the current one first, so no path leaves it unassigned (no latch).
        state_nx = state;
        case (state)
            IDLE:    state_nx = IDLE;
            RUN:     if (last_step) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A start wins in every state, aborting whatever was in flight.
        if (start) state_nx = div_zero ? DONE : RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sa       <= 1'b0;
            sb       <= 1'b0;
            ovf      <= 1'b0;
            abs_b    <= '0;
            r        <= '0;
            q        <= '0;
            count    <= '0;
            result_r <= '0;
            exc_r    <= 1'b0;
        end else if (start) begin
            sa    <= bus.data_operandA[WIDTH-1];
            sb    <= bus.data_operandB[WIDTH-1];
            abs_b <= abs_val(bus.data_operandB);
            r     <= '0;
            q     <= abs_val(bus.data_operandA);
            count <= '0;
            ovf   <= (bus.data_operandA == MIN_NEG) && (bus.data_operandB == '1);
            if (div_zero) begin
                result_r <= '0;
                exc_r    <= 1'b1;
            end
        end else begin
            case (state)
                RUN: begin
                    r     <= r_nx;
                    q     <= q_nx;
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (ovf) begin
                        result_r <= MIN_NEG;
                        exc_r    <= 1'b1;
                    end else begin
                        result_r <= (sa ^ sb) ? negate(q) : q;
                        exc_r    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = result_r;
    assign bus.data_exception = exc_r;
    assign bus.data_resultRDY = (state == DONE);
    assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: an arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_iter;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    div_iter_if bus ();

    div_iter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: signed division with plain integer arithmetic.
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic exc,
                                      output int lat);
        longint la;
        longint lb;
        la = $signed(a);
        lb = $signed(b);
        if (lb == 0) begin
            res = 32'h0; exc = 1'b1; lat = 0;
        end else if (la == -64'sd2147483648 && lb == -64'sd1) begin
            res = 32'h8000_0000; exc = 1'b1; lat = 33;
        end else begin
            res = 32'(la / lb); exc = 1'b0; lat = 33;
        end
    endfunction

    int          edge_n = 0;
    bit          pending = 1'b0;
    int          exp_edge = 0;
    logic [31:0] exp_res = '0;
    logic        exp_exc = 1'b0;

    always @(posedge clock or posedge reset) begin
        logic [31:0] m_res;
        logic        m_exc;
        int          m_lat;
        if (reset) begin
            pending <= 1'b0;
        end else begin
            edge_n <= edge_n + 1;
            if (bus.ctrl_DIV) begin
                model_div(bus.data_operandA, bus.data_operandB, m_res, m_exc, m_lat);
                pending  <= 1'b1;
                exp_edge <= edge_n + 1 + m_lat;
                exp_res  <= m_res;
                exp_exc  <= m_exc;
            end else if (pending && (edge_n + 1 > exp_edge)) begin
                pending <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        logic exp_rdy;
        exp_rdy = pending && (edge_n == exp_edge);
        check("model_rdy", {31'd0, bus.data_resultRDY}, {31'd0, exp_rdy});
        check("model_busy", {31'd0, bus.busy}, {31'd0, pending});
        if (exp_rdy) begin
            check("model_result", bus.data_result, exp_res);
            check("model_exception", {31'd0, bus.data_exception}, {31'd0, exp_exc});
        end
    end

    task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input int elat);
        int k;
        @(negedge clock);
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        k = 0;
        while (!bus.data_resultRDY && k < 60) begin
            @(negedge clock);
            k++;
        end
        if (!bus.data_resultRDY) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, 32'(k), 32'(elat));
            check({name, "_result"}, bus.data_result, er);
            check({name, "_exception"}, {31'd0, bus.data_exception}, {31'd0, ee});
        end
        @(negedge clock);
        check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_rdy_after"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          pulses;
        int          lat;
        logic [31:0] res;

        reset             = 1'b1;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;

        do_div("pos_pos",   32'd100,       32'd7,         32'h0000_000E, 1'b0, 33);
        do_div("neg_pos",   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 33);
        do_div("pos_neg",   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
        do_div("neg_neg",   32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 1'b0, 33);
        do_div("small",     32'd7,         32'd100,       32'h0000_0000, 1'b0, 33);
        do_div("div_zero",  32'h1234_5678, 32'h0,         32'h0000_0000, 1'b1, 0);
        do_div("overflow",  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
        do_div("min_by_2",  32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, 33);
        do_div("by_min",    32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 33);

        // Restart mid-RUN: only the second operation may complete.
        @(negedge clock);
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd3;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd50; bus.data_operandB = 32'd5;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        pulses = 0; lat = -1; res = '0;
        for (int k = 0; k < 60; k++) begin
            if (bus.data_resultRDY) begin
                pulses++;
                lat = k;
                res = bus.data_result;
            end
            @(negedge clock);
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_latency", 32'(lat), 32'd33);
        check("restart_result", res, 32'd10);

        // Asynchronous reset mid-RUN: outputs clear at once, no completion.
        @(negedge clock);
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd1000; bus.data_operandB = 32'd3;
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_result", bus.data_result, 32'h0);
        check("async_reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("async_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("async_reset_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.data_resultRDY) pulses++;
            @(negedge clock);
        end
        check("after_reset_pulses", 32'(pulses), 32'd0);
        do_div("post_reset", 32'd9, 32'd3, 32'd3, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
